spi_cmd_master: RTL and testbench

- Single-clock SPI command initiator that drives the SPI slave/RAM wrapper: mosi, ss_n out; miso in.
- Accepts 10-bit command words (din[9:8] opcode: 00 write-addr, 01 write-data, 10 read-addr, 11 read-data) on a valid/ready handshake and serialises each as one ss_n frame.
- For read-data commands, captures the 8-bit reply on miso and returns it on a one-cycle rd_valid strobe.
- Sits between the test/host sequencer and spi_wrapper; same clk as the slave, with no separate SCLK.

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_shift_out.sv | 33 +++
 rtl/spi_cmd_master.sv | 162 ++++++++++++++++
 tb/tb_spi_cmd_master.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command master and its testbench.
// Holds the frame geometry constants, the command opcode encoding, the
// master state encoding and a small helper used to size the bit counter.
package spi_pkg;

    localparam int FRAME_BITS = 10;
    localparam int RD_BITS    = 8;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_RECV,
        ST_GAP
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_shift_out.sv
// Loadable parallel-to-serial register, MSB first.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        capture data (takes priority over shift)
//   shift       move contents one place towards the MSB, zero fill
//   data        parallel word to load
//   msb         current most significant bit
module spi_shift_out #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             msb
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= data;
        end else if (shift) begin
            sr <= {sr[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sr[WIDTH-1];

endmodule

// File: rtl/spi_cmd_master.sv
// SPI command initiator sharing clk with the slave (no separate SCLK).
// Each accepted command word becomes one ss_n-low frame: the select bit
// (cmd_data[9]) followed by the 10-bit payload, MSB first. Read-data
// commands additionally wait RD_WAIT cycles and capture RD_BITS reply bits.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready command handshake (ready only in IDLE)
//   cmd_data            [9:8] opcode, [7:0] address/data
//   ss_n, mosi, miso    serial interface (ss_n, mosi registered)
//   rd_valid, rd_data   one-cycle strobe with the captured reply
//   busy                high whenever the FSM is not in IDLE
//
// state | meaning
// IDLE  | ready for a command, ss_n high
// SEND  | shifting the payload onto mosi, one bit per edge
// WAIT  | read turnaround, ss_n low, mosi 0
// RECV  | sampling the reply on miso
// GAP   | ss_n high for GAP_CYCLES before returning to IDLE
module spi_cmd_master
    import spi_pkg::*;
#(
    parameter int RD_WAIT    = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [FRAME_BITS-1:0] cmd_data,
    output logic                  ss_n,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  rd_valid,
    output logic [RD_BITS-1:0]    rd_data,
    output logic                  busy
);

    localparam int CNT_W = $clog2(max_int(max_int(FRAME_BITS + 1, RD_WAIT),
                                          max_int(RD_BITS, GAP_CYCLES)) + 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    opcode_t            op, op_nxt;
    logic               ss_nxt, mosi_nxt, ready_nxt, rd_valid_nxt;
    logic [RD_BITS-1:0] cap, cap_nxt, rd_data_nxt;
    logic               load, shift, sh_msb;

    spi_shift_out #(.WIDTH(FRAME_BITS)) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (shift),
        .data  (cmd_data),
        .msb   (sh_msb)
    );

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        op_nxt       = op;
        ss_nxt       = ss_n;
        mosi_nxt     = mosi;
        cap_nxt      = cap;
        rd_data_nxt  = rd_data;
        rd_valid_nxt = 1'b0;
        load         = 1'b0;
        shift        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    load      = 1'b1;
                    op_nxt    = opcode_t'(cmd_data[FRAME_BITS-1 -: 2]);
                    ss_nxt    = 1'b0;
                    mosi_nxt  = cmd_data[FRAME_BITS-1];
                    cnt_nxt   = '0;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                // The edge after the last payload bit closes the send phase;
                // reads keep ss_n low into the turnaround.
                if (int'(cnt) == FRAME_BITS) begin
                    cnt_nxt  = '0;
                    mosi_nxt = 1'b0;
                    if (op != RD_DATA) begin
                        ss_nxt    = 1'b1;
                        state_nxt = ST_GAP;
                    end else if (RD_WAIT == 0) begin
                        state_nxt = ST_RECV;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end else begin
                    mosi_nxt = sh_msb;
                    shift    = 1'b1;
                    cnt_nxt  = cnt + 1'b1;
                end
            end
            ST_WAIT: begin
                if (int'(cnt) == RD_WAIT - 1) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_RECV;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_RECV: begin
                cap_nxt = {cap[RD_BITS-2:0], miso};
                if (int'(cnt) == RD_BITS - 1) begin
                    rd_data_nxt  = cap_nxt;
                    rd_valid_nxt = 1'b1;
                    ss_nxt       = 1'b1;
                    cnt_nxt      = '0;
                    state_nxt    = ST_GAP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (int'(cnt) == GAP_CYCLES - 1) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // Registered ready tracks the next state so it stays low in reset
        // and rises on the first edge after release.
        ready_nxt = (state_nxt == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op        <= WR_ADDR;
            ss_n      <= 1'b1;
            mosi      <= 1'b0;
            cap       <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            op        <= op_nxt;
            ss_n      <= ss_nxt;
            mosi      <= mosi_nxt;
            cap       <= cap_nxt;
            rd_data   <= rd_data_nxt;
            rd_valid  <= rd_valid_nxt;
            cmd_ready <= ready_nxt;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_cmd_master.sv
module tb_spi_cmd_master;
    import spi_pkg::*;

    localparam int RD_WAIT    = 2;
    localparam int GAP_CYCLES = 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  cmd_valid = 1'b0;
    logic [FRAME_BITS-1:0] cmd_data = '0;
    logic                  miso = 1'b0;
    logic                  cmd_ready, ss_n, mosi, rd_valid, busy;
    logic [RD_BITS-1:0]    rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    spi_cmd_master #(.RD_WAIT(RD_WAIT), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .ss_n      (ss_n),
        .mosi      (mosi),
        .miso      (miso),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (cycle offset since acceptance) ----------------
    logic [7:0]            mram [0:255];
    logic [7:0]            maddr = '0;
    logic [FRAME_BITS-1:0] m_word = '0;
    int                    m_t = -1;
    bit                    m_started = 1'b0;
    logic [7:0]            m_reply = '0;
    logic [7:0]            m_rd_data = '0;

    function automatic int frame_len(input logic [FRAME_BITS-1:0] w);
        return (w[9:8] == 2'b11) ? FRAME_BITS + 1 + RD_WAIT + RD_BITS : FRAME_BITS + 1;
    endfunction

    always @(posedge clk) begin
        bit   acc;
        int   len;
        logic exp_ss, exp_mosi, exp_rdv, exp_rdy, exp_busy;
        if (!rst_n) begin
            m_t       = -1;
            m_started = 1'b0;
            m_rd_data = '0;
        end else begin
            len = frame_len(m_word);
            acc = cmd_valid && m_started && (m_t < 0 || m_t >= len + GAP_CYCLES);
            if (acc) begin
                m_word = cmd_data;
                m_t    = 0;
                case (cmd_data[9:8])
                    2'b00: maddr = cmd_data[7:0];
                    2'b01: mram[maddr] = cmd_data[7:0];
                    2'b10: maddr = cmd_data[7:0];
                    default: m_reply = mram[maddr];
                endcase
            end else if (m_t >= 0 && m_t < 100000) begin
                m_t++;
            end
            m_started = 1'b1;
            if (m_word[9:8] == 2'b11 && m_t == frame_len(m_word)) m_rd_data = m_reply;
        end
        len      = frame_len(m_word);
        exp_ss   = !(m_t >= 0 && m_t < len);
        exp_mosi = 1'b0;
        if (m_t == 0) exp_mosi = m_word[FRAME_BITS-1];
        else if (m_t >= 1 && m_t <= FRAME_BITS) exp_mosi = m_word[FRAME_BITS - m_t];
        exp_rdv  = (m_word[9:8] == 2'b11) && (m_t == len);
        exp_rdy  = m_started && (m_t < 0 || m_t >= len + GAP_CYCLES);
        exp_busy = (m_t >= 0 && m_t < len + GAP_CYCLES);
        #1;
        check("cyc_ss_n", ss_n, exp_ss);
        check("cyc_mosi", mosi, exp_mosi);
        check("cyc_rd_valid", rd_valid, exp_rdv);
        check("cyc_cmd_ready", cmd_ready, exp_rdy);
        check("cyc_busy", busy, exp_busy);
        check("cyc_rd_data", rd_data, m_rd_data);
    end

    // ---------------- slave with RAM, decoding the DUT's serial stream ----------------
    logic [7:0]        sram [0:255];
    logic [7:0]        saddr = '0;
    int                s_t = 0;
    logic [FRAME_BITS:0] s_sh = '0;
    logic [1:0]        s_op = '0;
    logic [7:0]        s_reply = '0;

    always @(negedge clk) begin
        if (ss_n) begin
            s_t  = 0;
            miso = 1'($urandom_range(0, 1));
        end else begin
            if (s_t <= FRAME_BITS) s_sh = {s_sh[FRAME_BITS-1:0], mosi};
            if (s_t == FRAME_BITS) begin
                s_op = s_sh[9:8];
                case (s_sh[9:8])
                    2'b00: saddr = s_sh[7:0];
                    2'b01: sram[saddr] = s_sh[7:0];
                    2'b10: saddr = s_sh[7:0];
                    default: s_reply = sram[saddr];
                endcase
            end
            if (s_op == 2'b11 && s_t >= FRAME_BITS + 1 + RD_WAIT &&
                s_t < FRAME_BITS + 1 + RD_WAIT + RD_BITS)
                miso = s_reply[RD_BITS - 1 - (s_t - (FRAME_BITS + 1 + RD_WAIT))];
            else
                miso = 1'($urandom_range(0, 1));
            s_t++;
        end
    end

    // ---------------- frame monitor ----------------
    int          frames = 0, low_len = 0, last_low_len = 0;
    int          high_len = 0, last_high_len = 0, rdv_count = 0;
    logic [31:0] bits = '0, last_bits = '0;

    always @(negedge clk) begin
        if (!ss_n) begin
            if (low_len == 0) begin
                frames++;
                last_high_len = high_len;
            end
            low_len++;
            bits     = {bits[30:0], mosi};
            high_len = 0;
        end else begin
            if (low_len != 0) begin
                last_low_len = low_len;
                last_bits    = bits;
                low_len      = 0;
                bits         = '0;
            end
            high_len++;
        end
        if (rd_valid) rdv_count++;
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [FRAME_BITS-1:0] w, input bit hold);
        int n = 0;
        cmd_data  = w;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", cmd_ready, 1'b1);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(cmd_ready && ss_n) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", cmd_ready, 1'b1);
    endtask

    task automatic loop_rw(input logic [7:0] a, input logic [7:0] d);
        int r0;
        r0 = rdv_count;
        send({2'b00, a}, 1'b0);
        send({2'b01, d}, 1'b0);
        send({2'b10, a}, 1'b0);
        send({2'b11, 8'h00}, 1'b0);
        wait_idle();
        check("loop_rdv_once", rdv_count, r0 + 1);
        check("loop_rd_data", rd_data, d);
    endtask

    initial begin
        int r0, f0;
        for (int a = 0; a < 256; a++) begin
            mram[a] = 8'(a) ^ 8'hC3;
            sram[a] = 8'(a) ^ 8'hC3;
        end
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_ss_n", ss_n, 1'b1);
        check("rst_mosi", mosi, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("ready_after_release", cmd_ready, 1'b1);
        @(negedge clk);

        // write-address frame
        r0 = rdv_count;
        send(10'h0A5, 1'b0);
        wait_idle();
        check("wa_len", last_low_len, 11);
        check("wa_bits", last_bits, 32'h0A5);
        check("wa_no_rdv", rdv_count, r0);

        // read-data frame, address 0 holds C3
        send(10'h200, 1'b0);
        send(10'h300, 1'b0);
        wait_idle();
        check("rd_len", last_low_len, 21);
        check("rd_bits", last_bits, 32'h1C0000);
        check("rd_rdv_once", rdv_count, r0 + 1);
        check("rd_data_c3", rd_data, 8'hC3);

        // back-to-back with cmd_valid held
        send(10'h012, 1'b1);
        send(10'h15A, 1'b0);
        wait_idle();
        check("b2b_gap", last_high_len, GAP_CYCLES + 1);
        check("b2b_len", last_low_len, 11);
        check("b2b_bits", last_bits, 32'h15A);

        // reset in the middle of a read-data frame
        r0 = rdv_count;
        send(10'h3FF, 1'b0);
        repeat (3) @(negedge clk);
        check("mid_ss_low", ss_n, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ss_n", ss_n, 1'b1);
        check("mid_rst_mosi", mosi, 1'b0);
        check("mid_rst_ready", cmd_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(10'h0A5, 1'b0);
        wait_idle();
        check("post_rst_len", last_low_len, 11);
        check("post_rst_bits", last_bits, 32'h0A5);
        check("post_rst_no_rdv", rdv_count, r0);

        // loopback through the slave RAM
        loop_rw(8'h12, 8'h5A);
        loop_rw(8'h00, 8'h00);
        loop_rw(8'hFF, 8'hFF);

        // cmd_valid pulse while busy is ignored
        f0 = frames;
        send(10'h1C3, 1'b0);
        repeat (2) @(negedge clk);
        cmd_data  = 10'h0FF;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        check("busy_frames", frames, f0 + 1);
        check("busy_bits", last_bits, 32'h1C3);
        check("busy_len", last_low_len, 11);

        // randomized traffic against the model
        repeat (3000) begin
            @(negedge clk);
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_data  = FRAME_BITS'($urandom);
        end
        cmd_valid = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not reach the summary, limit 2000000 time units");
        $fatal(1);
    end

endmodule
